// File: rtl/mul_pkg.sv
// Shared encodings for the multiply issue controller: op codes, multiplier modes,
// the per-stage tracking record and the default multiplier latency.
package mul_pkg;

   typedef enum logic [1:0] {
      OP_MUL    = 2'b00,
      OP_MULH   = 2'b01,
      OP_MULHSU = 2'b10,
      OP_MULHU  = 2'b11
   } mul_op_e;

   localparam logic [1:0] MODE_UU = 2'b00;
   localparam logic [1:0] MODE_SS = 2'b01;
   localparam logic [1:0] MODE_SU = 2'b11;

   localparam int MUL_LAT_DEF = 4;

   typedef struct packed {
      logic       vld;
      logic       sel_hi;
      logic [4:0] rd;
   } stage_t;

   function automatic logic [1:0] mode_of(input logic [1:0] op);
      case (op)
         OP_MULH:   mode_of = MODE_SS;
         OP_MULHSU: mode_of = MODE_SU;
         default:   mode_of = MODE_UU;
      endcase
   endfunction

endpackage

// File: rtl/mul_res_fifo.sv
// Synchronous result FIFO, one-cycle write-to-read; head is valid whenever !empty.
// A push while full is taken only if a pop happens in the same cycle; clear empties it.
module mul_res_fifo #(
   parameter int W     = 37,
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clear,
   input  logic          push,
   input  logic [W-1:0]  push_data,
   input  logic          pop,
   output logic [W-1:0]  head,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
      next_ptr = (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= next_ptr(wr_ptr);
         if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/mul_issue_ctrl.sv
// Issue/writeback control around a fixed-latency multiplier; result FIFO out_valid at C0+MUL_LAT+1
// (C0+MUL_LAT with MUL_RES_BYPASS_EN). in_ready is credit-based, so the never-stalling pipe cannot overflow.
module mul_issue_ctrl
   import mul_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int MUL_LAT   = MUL_LAT_DEF,
   parameter int RES_DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [1:0]      in_op,
   input  logic [XLEN-1:0] in_rs1,
   input  logic [XLEN-1:0] in_rs2,
   input  logic [4:0]      in_rd,
   input  logic            flush,
   output logic [XLEN-1:0] mul_a,
   output logic [XLEN-1:0] mul_b,
   output logic [1:0]      mul_mode,
   input  logic [XLEN-1:0] mul_hi,
   input  logic [XLEN-1:0] mul_lo,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_data,
   output logic [4:0]      out_rd
);

   localparam int CW = $clog2(RES_DEPTH + 1);
   localparam int FW = XLEN + 5;

   stage_t          pipe [1:MUL_LAT];
   stage_t          entry;
   logic            accept;
   logic            stage_vld;
   logic            push;
   logic            pop;
   logic            fifo_full;
   logic            fifo_empty;
   logic [CW-1:0]   fifo_count;
   logic [CW-1:0]   inflight;
   logic [XLEN-1:0] result;
   logic [FW-1:0]   head;

   assign mul_a    = in_rs1;
   assign mul_b    = in_rs2;
   assign mul_mode = mode_of(in_op);

   // Every accepted op owns a FIFO slot from issue until it is popped.
   assign in_ready = ~fifo_full &&
                     (({1'b0, inflight} + {1'b0, fifo_count}) < (CW + 1)'(RES_DEPTH));
   assign accept   = in_valid & in_ready & ~flush;

   always_comb begin
      entry        = '0;
      entry.vld    = accept;
      entry.sel_hi = (in_op != OP_MUL);
      entry.rd     = in_rd;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 1; k <= MUL_LAT; k++) pipe[k] <= '0;
      end else begin
         pipe[1] <= entry;
         for (int k = 2; k <= MUL_LAT; k++) begin
            if (flush) pipe[k] <= '0;
            else       pipe[k] <= pipe[k-1];
         end
      end
   end

   assign stage_vld = pipe[MUL_LAT].vld;
   assign result    = pipe[MUL_LAT].sel_hi ? mul_hi : mul_lo;

   // An op stops being in flight when it leaves the last stage, whether it
   // lands in the FIFO or goes straight out on the bypass.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inflight <= '0;
      end else if (flush) begin
         inflight <= '0;
      end else begin
         case ({accept, stage_vld})
            2'b10:   inflight <= inflight + 1'b1;
            2'b01:   inflight <= inflight - 1'b1;
            default: inflight <= inflight;
         endcase
      end
   end

   always_comb begin
      out_valid = ~fifo_empty;
      out_data  = '0;
      out_rd    = '0;
      push      = stage_vld;
      if (!fifo_empty) begin
         {out_rd, out_data} = head;
      end
`ifdef MUL_RES_BYPASS_EN
      else if (stage_vld && !flush) begin
         out_valid = 1'b1;
         out_data  = result;
         out_rd    = pipe[MUL_LAT].rd;
         push      = ~out_ready;
      end
`endif
   end

   assign pop = out_valid & out_ready & ~fifo_empty;

   mul_res_fifo #(
      .W     (FW),
      .DEPTH (RES_DEPTH),
      .CW    (CW)
   ) u_res_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (flush),
      .push      (push),
      .push_data ({pipe[MUL_LAT].rd, result}),
      .pop       (pop),
      .head      (head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Bench for mul_issue_ctrl: directed cases plus random traffic against a result-queue model.
module tb_mul_issue_ctrl;

   localparam int DEPTH = 4;
`ifdef MUL_RES_BYPASS_EN
   localparam int EXP_LAT = 4;
`else
   localparam int EXP_LAT = 5;
`endif

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_op;
   logic [31:0] in_rs1;
   logic [31:0] in_rs2;
   logic [4:0]  in_rd;
   logic        flush;
   logic [31:0] mul_a;
   logic [31:0] mul_b;
   logic [1:0]  mul_mode;
   logic [31:0] mul_hi;
   logic [31:0] mul_lo;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [4:0]  out_rd;

   int n_cmp = 0;
   int n_err = 0;

   logic [36:0] q[$];
   bit          last_pop;
   logic [4:0]  last_rd;

   mul_issue_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_rs1    (in_rs1),
      .in_rs2    (in_rs2),
      .in_rd     (in_rd),
      .flush     (flush),
      .mul_a     (mul_a),
      .mul_b     (mul_b),
      .mul_mode  (mul_mode),
      .mul_hi    (mul_hi),
      .mul_lo    (mul_lo),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_rd    (out_rd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // External 4-cycle multiplier driven by the DUT's operand/mode outputs.
   function automatic logic [63:0] model_prod(input logic [31:0] a, input logic [31:0] b,
                                              input logic [1:0] mode);
      logic [63:0] a64;
      logic [63:0] b64;
      a64 = mode[0] ? {{32{a[31]}}, a} : {32'b0, a};
      b64 = (mode == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
      return a64 * b64;
   endfunction

   logic [63:0] mpipe [1:4];
   always @(posedge clk) begin
      mpipe[1] <= model_prod(mul_a, mul_b, mul_mode);
      for (int k = 2; k <= 4; k++) mpipe[k] <= mpipe[k-1];
   end
   assign mul_hi = mpipe[4][63:32];
   assign mul_lo = mpipe[4][31:0];

   // Architectural result of each op from plain integer arithmetic.
   function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      longint unsigned ua, ub;
      longint          sa, sb;
      logic [63:0]     uu, ss, su;
      ua = a; ub = b;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      uu = ua * ub;
      ss = sa * sb;
      su = sa * longint'(ub);
      case (op)
         2'd0:    return uu[31:0];
         2'd1:    return ss[63:32];
         2'd2:    return su[63:32];
         default: return uu[63:32];
      endcase
   endfunction

   function automatic logic [1:0] exp_mode(input logic [1:0] op);
      case (op)
         2'd1:    return 2'b01;
         2'd2:    return 2'b11;
         default: return 2'b00;
      endcase
   endfunction

   function automatic logic [31:0] rand_operand();
      case ($urandom_range(0, 5))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock: compare against the model, update it, advance to the next negedge.
   task automatic tick(output bit acc);
      logic [36:0] e;
      #1;
      check("in_ready", in_ready, q.size() < DEPTH);
      check("mul_a", mul_a, in_rs1);
      check("mul_b", mul_b, in_rs2);
      check("mul_mode", mul_mode, exp_mode(in_op));
      acc      = in_valid && in_ready && !flush;
      last_pop = 0;
      if (flush) begin
         q.delete();
      end else begin
         if (q.size() == 0) begin
            check("idle_out_valid", out_valid, 1'b0);
         end else if (out_valid) begin
            e = q[0];
            check("out_data", out_data, e[31:0]);
            check("out_rd", out_rd, e[36:32]);
            if (out_ready) begin
               void'(q.pop_front());
               last_pop = 1;
               last_rd  = out_rd;
            end
         end
         if (acc) q.push_back({in_rd, ref_res(in_op, in_rs1, in_rs2)});
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic issue_lat(input string tag, input logic [1:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] rd,
                            input logic [1:0] mode, input logic [31:0] data);
      bit acc;
      int lat;
      in_valid = 1; in_op = op; in_rs1 = a; in_rs2 = b; in_rd = rd; out_ready = 1;
      #1;
      check({tag, "_mode"}, mul_mode, mode);
      tick(acc);
      check({tag, "_accept"}, acc, 1'b1);
      in_valid = 0;
      lat = 0;
      for (int i = 1; i <= 10 && lat == 0; i++) begin
         #1;
         if (out_valid) begin
            lat = i;
            check({tag, "_data"}, out_data, data);
            check({tag, "_rd"}, out_rd, rd);
         end
         tick(acc);
      end
      check({tag, "_latency"}, lat, EXP_LAT);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1);
   end

   initial begin
      bit acc;
      int rd_next;
      int pops[$];
      int pops_at_5;

      rst_n = 0; in_valid = 0; in_op = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0;
      flush = 0; out_ready = 0;
      #1;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_data", out_data, 32'h0);
      check("rst_out_rd", out_rd, 5'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1;
      #1;
      check("rel_in_ready", in_ready, 1'b1);
      tick(acc);

      // Single-op latency and result selection.
      issue_lat("mulhu", 2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 2'b00, 32'hFFFF_FFFE);
      issue_lat("mulh", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 2'b01, 32'h0000_0000);
      issue_lat("mulhsu", 2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, 2'b11, 32'hFFFF_FFFF);
      issue_lat("mul", 2'd0, 32'h1234_5678, 32'h0000_0010, 5'd11, 2'b00, 32'h2345_6780);
      for (int i = 0; i < 3; i++) tick(acc);

      // Credit limit with a stalled consumer, then in-order drain.
      out_ready = 0;
      rd_next = 1;
      for (int i = 0; i < 6; i++) begin
         in_valid = 1; in_op = 2'($urandom_range(0, 3));
         in_rs1 = rand_operand(); in_rs2 = rand_operand(); in_rd = 5'(rd_next);
         tick(acc);
         if (acc) rd_next++;
      end
      check("b2b_accepts", rd_next - 1, 4);
      check("b2b_in_ready_low", in_ready, 1'b0);
      for (int i = 0; i < 6; i++) tick(acc);
      check("b2b_full_hold", rd_next, 5);
      out_ready = 1;
      pops_at_5 = -1;
      for (int i = 0; i < 40 && pops.size() < 6; i++) begin
         in_valid = (rd_next <= 6);
         in_rd    = 5'(rd_next);
         tick(acc);
         if (acc) begin
            if (rd_next == 5) pops_at_5 = pops.size();
            rd_next++;
         end
         if (last_pop) pops.push_back(int'(last_rd));
      end
      in_valid = 0;
      check("b2b_pop_count", pops.size(), 6);
      for (int i = 0; i < pops.size(); i++) check("b2b_order", pops[i], i + 1);
      check("b2b_5_after_pop", pops_at_5 >= 1, 1'b1);

      // Flush two cycles after the third of three accepts.
      for (int i = 0; i < 3; i++) begin
         in_valid = 1; in_op = 2'd0; in_rs1 = $urandom; in_rs2 = $urandom; in_rd = 5'(20 + i);
         tick(acc);
         check("fl_accept", acc, 1'b1);
      end
      in_valid = 0;
      tick(acc);
      flush = 1;
      tick(acc);
      flush = 0;
      check("fl_in_ready", in_ready, 1'b1);
      for (int i = 0; i < 8; i++) begin
         #1;
         check("fl_no_out_valid", out_valid, 1'b0);
         tick(acc);
      end

      // Reset while two results sit in the FIFO.
      out_ready = 0;
      for (int i = 0; i < 2; i++) begin
         in_valid = 1; in_op = 2'd3; in_rs1 = $urandom; in_rs2 = $urandom; in_rd = 5'(30 + i);
         tick(acc);
      end
      in_valid = 0;
      for (int i = 0; i < 6; i++) tick(acc);
      check("rst2_buffered", out_valid, 1'b1);
      rst_n = 0;
      #2;
      check("rst2_out_valid", out_valid, 1'b0);
      check("rst2_out_data", out_data, 32'h0);
      @(negedge clk);
      rst_n = 1;
      q.delete();
      #1;
      check("rst2_in_ready", in_ready, 1'b1);
      check("rst2_out_data_rel", out_data, 32'h0);
      out_ready = 1;
      for (int i = 0; i < 8; i++) tick(acc);

      // Random traffic against the queue model.
      for (int i = 0; i < 500; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_op     = 2'($urandom_range(0, 3));
         in_rs1    = rand_operand();
         in_rs2    = rand_operand();
         in_rd     = 5'($urandom);
         out_ready = ($urandom_range(0, 9) < 7);
         flush     = ($urandom_range(0, 49) == 0);
         tick(acc);
      end
      in_valid = 0; flush = 0; out_ready = 1;
      for (int i = 0; i < 40 && q.size() > 0; i++) tick(acc);
      check("drain_empty", q.size(), 0);
      for (int i = 0; i < 4; i++) tick(acc);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
